// File: rtl/vend_pkg.sv
// Shared definitions for the drink dispenser: drink codes, FSM states,
// queued request format and timing defaults.
package vend_pkg;

    localparam logic [1:0] DRINK_NONE  = 2'b00;
    localparam logic [1:0] DRINK_WATER = 2'b01;
    localparam logic [1:0] DRINK_COKE  = 2'b10;

    localparam int MOTOR_CYCLES_DEF = 8;
    localparam int HOPPER_ON_DEF    = 4;
    localparam int HOPPER_OFF_DEF   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISPENSE,
        ST_GAP,
        ST_REFUND_ON,
        ST_REFUND_OFF
    } state_e;

    typedef struct packed {
        logic [1:0] drink;
        logic [1:0] refund;
    } req_t;

endpackage

// File: rtl/req_fifo.sv
// Two-entry request queue between the edge detector and the dispense FSM.
// A push on a full queue is accepted only when a pop happens on the same edge.
module req_fifo
    import vend_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  req_t wdata,
    output req_t rdata,
    output logic full,
    output logic empty
);

    req_t       mem_q [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;
    logic       do_push, do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q ^ do_push;
        rd_d  = rd_q ^ do_pop;
        cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata;
            end
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dispense_ctrl.sv
// Drink motor and coin-hopper sequencer fed by a two-entry request queue.
// Outputs are registered from the next state so they align with state entry.
module dispense_ctrl
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES = MOTOR_CYCLES_DEF,
    parameter int HOPPER_ON    = HOPPER_ON_DEF,
    parameter int HOPPER_OFF   = HOPPER_OFF_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] drink_req,
    input  logic [1:0] refund_req,
    output logic       motor_on,
    output logic [1:0] motor_sel,
    output logic       hopper_pulse,
    output logic       busy,
    output logic       overflow
);

    // Counters hold "cycles left minus one" so a state lasts load+1 cycles.
    localparam logic [7:0] MOTOR_LOAD = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0] HON_LOAD   = 8'(HOPPER_ON - 1);
    localparam logic [7:0] HOFF_LOAD  = 8'(HOPPER_OFF - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] rem_q, rem_d;
    logic [1:0] drink_q, drink_d;
    logic [3:0] hist_q;
    logic       motor_on_q, motor_on_d;
    logic [1:0] motor_sel_q, motor_sel_d;
    logic       hopper_q, hopper_d;
    logic       overflow_q, overflow_d;

    logic evt, push, pop;
    logic fifo_full, fifo_empty;
    req_t push_req, head;

    assign evt  = ({drink_req, refund_req} != 4'd0) && (hist_q == 4'd0);
    assign pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign push = evt && (!fifo_full || pop);
    assign push_req = {(drink_req == 2'b11) ? DRINK_NONE : drink_req,
                       refund_req};

    req_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_req),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        drink_d    = drink_q;
        overflow_d = overflow_q | (evt && fifo_full && !pop);
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    drink_d = head.drink;
                    rem_d   = head.refund;
                    if (head.drink != DRINK_NONE) begin
                        state_d = ST_DISPENSE;
                        cnt_d   = MOTOR_LOAD;
                    end else if (head.refund != 2'd0) begin
                        state_d = ST_REFUND_ON;
                        cnt_d   = HON_LOAD;
                    end
                end
            end
            ST_DISPENSE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (rem_q != 2'd0) begin
                    state_d = ST_GAP;
                    cnt_d   = HOFF_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            ST_GAP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = ST_REFUND_ON;
                    cnt_d   = HON_LOAD;
                end
            end
            ST_REFUND_ON: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = ST_REFUND_OFF;
                    cnt_d   = HOFF_LOAD;
                end
            end
            ST_REFUND_OFF: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (rem_q > 2'd1) begin
                    rem_d   = rem_q - 2'd1;
                    state_d = ST_REFUND_ON;
                    cnt_d   = HON_LOAD;
                end else begin
                    rem_d   = 2'd0;
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                rem_d   = 2'd0;
            end
        endcase
        motor_on_d  = (state_d == ST_DISPENSE);
        motor_sel_d = motor_on_d ? drink_d : DRINK_NONE;
        hopper_d    = (state_d == ST_REFUND_ON);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            rem_q       <= 2'd0;
            drink_q     <= DRINK_NONE;
            hist_q      <= 4'd0;
            motor_on_q  <= 1'b0;
            motor_sel_q <= DRINK_NONE;
            hopper_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            drink_q     <= drink_d;
            hist_q      <= {drink_req, refund_req};
            motor_on_q  <= motor_on_d;
            motor_sel_q <= motor_sel_d;
            hopper_q    <= hopper_d;
            overflow_q  <= overflow_d;
        end
    end

    assign motor_on     = motor_on_q;
    assign motor_sel    = motor_sel_q;
    assign hopper_pulse = hopper_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dispense_ctrl.sv
// Directed bench for dispense_ctrl: single-request vector table plus
// hand-built queueing, overflow and reset sequences.
module tb_dispense_ctrl;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] drink_req = 2'b00;
    logic [1:0] refund_req = 2'b00;
    logic       motor_on;
    logic [1:0] motor_sel;
    logic       hopper_pulse;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dispense_ctrl #(
        .MOTOR_CYCLES (8),
        .HOPPER_ON    (4),
        .HOPPER_OFF   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .drink_req    (drink_req),
        .refund_req   (refund_req),
        .motor_on     (motor_on),
        .motor_sel    (motor_sel),
        .hopper_pulse (hopper_pulse),
        .busy         (busy),
        .overflow     (overflow)
    );

    typedef struct {
        logic [1:0] d;
        logic [1:0] r;
        int         motor_hi;
        logic [1:0] sel;
        int         hop_hi;
        int         hop_rises;
        int         busy_hi;
        int         motor_first;
        int         hop_first;
    } vec_t;

    vec_t vecs[7];

    logic [1:0] stim_d[64];
    logic [1:0] stim_r[64];

    int         motor_hi, hop_hi, motor_rises, hop_rises, busy_hi;
    int         motor_first, hop_first, sel_bad, overlap;
    logic [1:0] sel_or;
    int         rise_at[4];
    logic [1:0] rise_sel[4];
    logic       ovf_tr[64];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 64; i++) begin
            stim_d[i] = 2'b00;
            stim_r[i] = 2'b00;
        end
    endtask

    // Sample index i is taken #1 after the edge that samples stim[i].
    task automatic run(input int n);
        logic       pm, ph;
        logic [1:0] cur_sel;
        motor_hi = 0; hop_hi = 0; motor_rises = 0; hop_rises = 0;
        busy_hi = 0; motor_first = -1; hop_first = -1;
        sel_bad = 0; overlap = 0; sel_or = 2'b00;
        pm = 1'b0; ph = 1'b0; cur_sel = 2'b00;
        for (int k = 0; k < 4; k++) begin
            rise_at[k] = -1;
            rise_sel[k] = 2'b00;
        end
        for (int i = 0; i < n; i++) begin
            drink_req = stim_d[i];
            refund_req = stim_r[i];
            @(posedge clk);
            #1;
            if (motor_on) motor_hi++;
            if (hopper_pulse) hop_hi++;
            if (busy) busy_hi++;
            if (motor_on && hopper_pulse) overlap++;
            if (motor_on && !pm) begin
                if (motor_rises < 4) begin
                    rise_at[motor_rises] = i;
                    rise_sel[motor_rises] = motor_sel;
                end
                motor_rises++;
                if (motor_first < 0) motor_first = i;
                cur_sel = motor_sel;
            end
            if (hopper_pulse && !ph) begin
                hop_rises++;
                if (hop_first < 0) hop_first = i;
            end
            if (motor_on && motor_sel != cur_sel) sel_bad++;
            if (!motor_on && motor_sel != 2'b00) sel_bad++;
            sel_or = sel_or | motor_sel;
            ovf_tr[i] = overflow;
            pm = motor_on;
            ph = hopper_pulse;
        end
        drink_req = 2'b00;
        refund_req = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{2'b01, 2'd0, 8, 2'b01, 0, 0, 9, 1, -1};
        vecs[1] = '{2'b10, 2'd1, 8, 2'b10, 4, 1, 21, 1, 13};
        vecs[2] = '{2'b00, 2'd3, 0, 2'b00, 12, 3, 25, -1, 1};
        vecs[3] = '{2'b01, 2'd2, 8, 2'b01, 8, 2, 29, 1, 13};
        vecs[4] = '{2'b11, 2'd0, 0, 2'b00, 0, 0, 1, -1, -1};
        vecs[5] = '{2'b11, 2'd2, 0, 2'b00, 8, 2, 17, -1, 1};
        vecs[6] = '{2'b10, 2'd0, 8, 2'b10, 0, 0, 9, 1, -1};

        #3;
        chk("rst motor_on", int'(motor_on), 0);
        chk("rst motor_sel", int'(motor_sel), 0);
        chk("rst hopper", int'(hopper_pulse), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst overflow", int'(overflow), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 7; v++) begin
            clear_stim();
            stim_d[0] = vecs[v].d;
            stim_r[0] = vecs[v].r;
            run(40);
            chk($sformatf("v%0d motor_hi", v), motor_hi, vecs[v].motor_hi);
            chk($sformatf("v%0d sel", v), int'(sel_or), int'(vecs[v].sel));
            chk($sformatf("v%0d hop_hi", v), hop_hi, vecs[v].hop_hi);
            chk($sformatf("v%0d hop_rises", v), hop_rises, vecs[v].hop_rises);
            chk($sformatf("v%0d busy_hi", v), busy_hi, vecs[v].busy_hi);
            chk($sformatf("v%0d motor_first", v), motor_first,
                vecs[v].motor_first);
            chk($sformatf("v%0d hop_first", v), hop_first, vecs[v].hop_first);
            chk($sformatf("v%0d sel_bad", v), sel_bad, 0);
            chk($sformatf("v%0d overlap", v), overlap, 0);
        end
        chk("vec overflow", int'(overflow), 0);

        // Request held for 5 cycles is one event.
        clear_stim();
        for (int i = 0; i < 5; i++) stim_d[i] = 2'b01;
        run(30);
        chk("held motor_hi", motor_hi, 8);
        chk("held rises", motor_rises, 1);
        chk("held busy_hi", busy_hi, 9);

        // Fill the queue, then push on the same edge as a pop from full.
        clear_stim();
        stim_d[0] = 2'b01;
        stim_d[2] = 2'b01;
        stim_d[4] = 2'b01;
        stim_d[10] = 2'b10;
        run(45);
        chk("pp rises", motor_rises, 4);
        chk("pp motor_hi", motor_hi, 32);
        chk("pp rise1", rise_at[1], 10);
        chk("pp rise3", rise_at[3], 28);
        chk("pp sel3", int'(rise_sel[3]), 2);
        chk("pp overflow", int'(overflow), 0);

        // Four events during a dispense: two queued, two dropped.
        clear_stim();
        stim_d[0] = 2'b01;
        stim_d[2] = 2'b10;
        stim_d[4] = 2'b01;
        stim_d[6] = 2'b10;
        stim_d[8] = 2'b01;
        run(40);
        chk("ovf rises", motor_rises, 3);
        chk("ovf motor_hi", motor_hi, 24);
        chk("ovf rise0", rise_at[0], 1);
        chk("ovf rise1", rise_at[1], 10);
        chk("ovf rise2", rise_at[2], 19);
        chk("ovf sel0", int'(rise_sel[0]), 1);
        chk("ovf sel1", int'(rise_sel[1]), 2);
        chk("ovf sel2", int'(rise_sel[2]), 1);
        chk("ovf busy_hi", busy_hi, 27);
        chk("ovf before", int'(ovf_tr[4]), 0);
        chk("ovf set", int'(ovf_tr[6]), 1);
        chk("ovf sticky", int'(overflow), 1);

        // Reset in the third motor cycle with one entry queued.
        clear_stim();
        stim_d[0] = 2'b01;
        stim_d[2] = 2'b10;
        run(4);
        chk("pre-rst motor_on", int'(motor_on), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort motor_on", int'(motor_on), 0);
        chk("abort motor_sel", int'(motor_sel), 0);
        chk("abort hopper", int'(hopper_pulse), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort overflow", int'(overflow), 0);
        @(negedge clk);
        rst = 1'b1;
        clear_stim();
        run(15);
        chk("lost motor_hi", motor_hi, 0);
        chk("lost busy_hi", busy_hi, 0);
        chk("lost hop_hi", hop_hi, 0);
        clear_stim();
        stim_d[0] = 2'b10;
        run(15);
        chk("fresh motor_hi", motor_hi, 8);
        chk("fresh first", motor_first, 1);
        chk("fresh sel", int'(rise_sel[0]), 2);
        chk("fresh busy_hi", busy_hi, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dispense_ctrl.md
DISPENSE_CTRL -- requirements
Module: dispense_ctrl

Interface
REQ-001 Parameter MOTOR_CYCLES, default 8: cycles motor_on stays high per drink (legal range 1..255).
REQ-002 Parameter HOPPER_ON, default 4: high cycles of each hopper_pulse (legal range 1..15).
REQ-003 Parameter HOPPER_OFF, default 4: low cycles after each hopper_pulse, and after a drink before a refund starts (legal range 1..15).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 drink_req  input  2  from vending fsm drink_out: 00 none, 01 water, 10 coke, 11 reserved.
REQ-007 refund_req  input  2  from vending fsm refund: number of coins to return, 0..3.
REQ-008 motor_on  output  1  drive for the selected dispense motor.
REQ-009 motor_sel  output  2  drink being dispensed (01/10); 00 when motor_on low.
REQ-010 hopper_pulse  output  1  coin-hopper eject pulse; one pulse per refunded coin.
REQ-011 busy  output  1  high whenever state is not IDLE or the queue is non-empty.
REQ-012 overflow  output  1  sticky; set when a request is dropped.

Function
REQ-013 Request event: {drink_req,refund_req} nonzero in cycle k AND zero in cycle k-1; held values raise no repeat events.
REQ-014 Event latches {drink,refund} into a 2-entry FIFO at edge k; drink_req 11 is enqueued as drink 00, and its refund field is kept.
REQ-015 Event while FIFO full, with no pop on the same edge: entry dropped, overflow set.
REQ-016 Simultaneous push and pop on a full FIFO: both take effect; no overflow.
REQ-017 States: IDLE, DISPENSE, GAP, REFUND_ON, REFUND_OFF (3-bit encoding).
REQ-018 IDLE with FIFO non-empty: pop at the next edge, then go to DISPENSE if drink != 00, else REFUND_ON if refund != 0, else stay IDLE.
REQ-019 DISPENSE: motor_on=1 and motor_sel=drink for exactly MOTOR_CYCLES cycles; then GAP if refund != 0, else IDLE.
REQ-020 GAP: HOPPER_OFF cycles with all outputs low; then REFUND_ON.
REQ-021 REFUND_ON: hopper_pulse=1 for HOPPER_ON cycles; then REFUND_OFF.
REQ-022 REFUND_OFF: HOPPER_OFF low cycles, then decrement remaining; go to REFUND_ON if remaining > 0, else IDLE.
REQ-023 Latency: event at edge k gives motor_on (or hopper_pulse) high from edge k+1 to edge k+1+MOTOR_CYCLES.
REQ-024 Back-to-back queued entries: IDLE lasts exactly one cycle between them.
REQ-025 The cycle counter is 8 bits and reloads on every state entry; the counter never wraps.
REQ-026 The remaining-coin counter is 2 bits; it never underflows.
REQ-027 Outputs are registered; motor_on and hopper_pulse are never high in the same cycle.

Reset
REQ-028 rst low: state=IDLE, FIFO empty, counters 0, edge-detect history 0; motor_on=0, motor_sel=00, hopper_pulse=0, busy=0, overflow=0, all asynchronously.
REQ-029 Reset mid-dispense or mid-refund aborts at once; queued entries are lost.
REQ-030 Release is synchronous to clk; the first event is recognised on the first edge after release.

Structure
REQ-031 The shared package vend_pkg holds the drink codes (NONE/WATER/COKE), the state enum, and the defaults for MOTOR_CYCLES, HOPPER_ON and HOPPER_OFF.
REQ-032 One sub-module, req_fifo: 2-entry 4-bit FIFO with push/pop/full/empty; the FSM, counters and edge detect stay in dispense_ctrl.

Verification
REQ-033 drink_req=01 for 1 cycle, refund 0 -> motor_sel=01 and motor_on high 8 cycles starting 1 edge later; busy then falls; hopper_pulse never high.
REQ-034 drink_req=10 with refund_req=01 -> 8 motor cycles, 4 low cycles, 1 hopper_pulse of 4 cycles, then IDLE.
REQ-035 drink_req=00 with refund_req=11 -> exactly 3 hopper_pulses of 4 high/4 low; motor_on stays 0.
REQ-036 drink_req=01 held 5 cycles -> exactly one dispense.
REQ-037 Four events spaced 2 cycles apart during a dispense -> two are queued, the remainder are dropped, overflow=1 until reset, and exactly 3 dispenses occur (the active one plus 2 queued).
REQ-038 rst asserted at motor cycle 3 -> all outputs 0 immediately; a fresh request after release is serviced normally.
